// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command-driven sequencer for an 8-bit select-controlled shift register
// Loads, shifts amount times, captures sr_q and returns it over a valid/ready result port.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_amount,
  output logic [1:0]       sr_select,
  output logic [WIDTH-1:0] sr_data,
  input  logic [WIDTH-1:0] sr_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic [CNT_W-1:0] r_count;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             w_accept;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign sr_data   = r_data;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  always_comb begin
    w_next    = r_state;
    sr_select = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        sr_select = 2'b11;
        w_next    = (r_count != '0) ? S_SHIFT : S_CAPTURE;
      end
      S_SHIFT: begin
        sr_select = r_dir ? 2'b10 : 2'b01;
        if (r_count == CNT_W'(1)) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The count is taken straight from the command so it already equals amount during LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_dir       <= 1'b0;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_data  <= cmd_data;
        r_dir   <= cmd_dir;
        r_count <= cmd_amount;
      end
      if (r_state == S_SHIFT) r_count <= r_count - CNT_W'(1);
      if (r_state == S_CAPTURE) begin
        r_res_data  <= sr_q;
        r_res_valid <= 1'b1;
      end
      if ((r_state == S_DONE) && res_ready) r_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer with a behavioural shift register
// Commands push reference results at acceptance; results are popped and compared at handshake.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic       cmd_dir = 1'b0;
  logic [2:0] cmd_amount = '0;
  logic [1:0] sr_select;
  logic [7:0] sr_data;
  logic [7:0] sr_q = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  shift_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_amount(cmd_amount),
    .sr_select(sr_select), .sr_data(sr_data), .sr_q(sr_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural shift register: zero fill, one bit per edge.
  always @(posedge clk) begin
    case (sr_select)
      2'b11:   sr_q <= sr_data;
      2'b01:   sr_q <= {sr_q[6:0], 1'b0};
      2'b10:   sr_q <= {1'b0, sr_q[7:1]};
      default: sr_q <= sr_q;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic dir, input logic [2:0] amt);
    return dir ? (d >> amt) : (d << amt);
  endfunction

  // Inputs are stable at the falling edge, so handshakes seen here are the ones taken at the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) exp_q.push_back(ref_shift(cmd_data, cmd_dir, cmd_amount));
      if (res_valid && res_ready) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("sb_res_data", res_data, exp_q.pop_front());
      end
    end
  end

  task automatic drive_cmd(input logic [7:0] d, input logic dir, input logic [2:0] amt, input bit keep);
    int n = 0;
    cmd_data = d; cmd_dir = dir; cmd_amount = amt; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("cmd_ready_accept", cmd_ready, 1);
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Entered 1 time unit after the accept edge; leaves 1 time unit after the result handshake edge.
  task automatic follow(input logic [7:0] d, input logic dir, input logic [2:0] amt, input int stall);
    logic [7:0] held;
    res_ready = (stall == 0);
    check("busy_load", busy, 1);
    check("sel_load", sr_select, 2'b11);
    check("sr_data_load", sr_data, d);
    check("cmd_ready_busy", cmd_ready, 0);
    for (int k = 1; k <= int'(amt); k++) begin
      @(posedge clk); #1;
      check("sel_shift", sr_select, dir ? 2'b10 : 2'b01);
      check("res_valid_early", res_valid, 0);
    end
    @(posedge clk); #1;
    check("sel_capture", sr_select, 2'b00);
    check("res_valid_capture", res_valid, 0);
    @(posedge clk); #1;
    check("res_valid_latency", res_valid, 1);
    check("sel_done", sr_select, 2'b00);
    check("res_data_ref", res_data, ref_shift(d, dir, amt));
    held = res_data;
    for (int s = 0; s < stall; s++) begin
      if (s == 1) begin
        cmd_data = 8'hC3; cmd_valid = 1'b1;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("stall_res_valid", res_valid, 1);
      check("stall_res_data", res_data, held);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_busy", busy, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("post_res_valid", res_valid, 0);
    check("post_busy", busy, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_sel", sr_select, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_sel", sr_select, 2'b00);
    check("rst_sr_data", sr_data, 8'h00);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 8'h00);
    check("rst_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_cmd_ready", cmd_ready, 1);

    drive_cmd(8'b00110011, 1'b0, 3'd1, 1'b0);
    follow(8'b00110011, 1'b0, 3'd1, 0);

    drive_cmd(8'b00110011, 1'b1, 3'd2, 1'b0);
    follow(8'b00110011, 1'b1, 3'd2, 0);

    drive_cmd(8'b00110011, 1'b0, 3'd0, 1'b0);
    follow(8'b00110011, 1'b0, 3'd0, 0);

    drive_cmd(8'h96, 1'b1, 3'd3, 1'b0);
    follow(8'h96, 1'b1, 3'd3, 5);

    drive_cmd(8'hA5, 1'b0, 3'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_sel_shift", sr_select, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_sel", sr_select, 2'b00);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_cmd(8'hFF, 1'b1, 3'd4, 1'b0);
    follow(8'hFF, 1'b1, 3'd4, 0);
    check("mid_new_result", res_data, 8'h0F);

    drive_cmd(8'h81, 1'b0, 3'd2, 1'b1);
    cmd_data = 8'h3C; cmd_dir = 1'b1; cmd_amount = 3'd5;
    follow(8'h81, 1'b0, 3'd2, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    follow(8'h3C, 1'b1, 3'd5, 0);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      logic       dir;
      logic [2:0] amt;
      d = 8'($urandom);
      dir = 1'($urandom);
      amt = 3'($urandom_range(0, 7));
      drive_cmd(d, dir, amt, 1'b0);
      follow(d, dir, amt, i % 3);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller that sequences the 8-bit select-controlled shift register. It accepts one command per transaction (data, direction, shift amount) over a valid/ready handshake. It then drives the register's select and parallel-data inputs over several cycles, captures the register output and returns it over a second valid/ready handshake. It sits between a requesting block and the shiftregister instance and is the only driver of that instance's select and data inputs.

Parameters:
WIDTH, 8, data width of the controlled shift register
CNT_W, 3, width of the shift-amount field; covers amounts 0..2^CNT_W-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_data  input  WIDTH  value to load into the register
cmd_dir  input  1  0 = shift left, 1 = shift right
cmd_amount  input  CNT_W  number of single-bit shifts
sr_select  output  2  select to shift register: 00 hold, 01 shift left, 10 shift right, 11 parallel load
sr_data  output  WIDTH  parallel-load data to shift register
sr_q  input  WIDTH  shift register registered output
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured register value
busy  output  1  high in any state other than IDLE

Behaviour:
- Shift register contract: 11 loads sr_data on the next edge. 01/10 shift by one bit per edge with zero fill. 00 holds. sr_q reflects the edge result in the following cycle.
- Asynchronous reset (rst_n low) puts the FSM in IDLE and clears the outputs: sr_select=00, sr_data=0, res_valid=0, res_data=0, busy=0. The shift count resets to 0. cmd_ready=1 once rst_n is high.
- FSM states are IDLE, LOAD, SHIFT, CAPTURE and DONE.
- IDLE: cmd_ready=1, sr_select=00. When cmd_valid && cmd_ready at an edge, the controller latches cmd_data, cmd_dir and cmd_amount and moves to LOAD.
- LOAD (1 cycle): sr_select=11, sr_data=latched data. Next state is SHIFT if amount != 0, else CAPTURE. The count register is loaded with amount.
- SHIFT: sr_select=01 (dir=0) or 10 (dir=1). The count decrements each edge. The controller leaves for CAPTURE on the edge where count==1. The state lasts exactly amount cycles.
- CAPTURE (1 cycle): sr_select=00. On the edge, res_data<=sr_q, res_valid<=1, and the FSM moves to DONE.
- DONE: sr_select=00. res_valid and res_data are held stable until res_ready is high at an edge. On that edge res_valid<=0 and the FSM moves to IDLE.
- cmd_ready is combinational: 1 only in IDLE. cmd_valid in any other state is ignored and not queued.
- Latency: res_valid rises amount+2 edges after the accept edge. For example, amount=1 gives res_valid in the cycle after the 3rd edge.
- Back-to-back throughput: the next command can be accepted one edge after the result handshake.
- sr_data holds the latched value outside LOAD. It is not required to be zero.
- res_ready high while res_valid is low has no effect.
- Reset asserted mid-operation (any state) aborts immediately; the result is lost and the shift register contents are don't-care.
- busy = (state != IDLE).
- Any cmd_amount value is legal. An amount greater than or equal to WIDTH yields 0.

Test Plan:
- Load 8'b00110011, dir=0, amount=1, res_ready=1 -> sr_select sequence 11,01,00; res_data=8'b01100110; res_valid 3 edges after accept.
- Load 8'b00110011, dir=1, amount=2 -> sr_select 11,10,10,00; res_data=8'b00001100; res_valid 4 edges after accept.
- Load 8'b00110011, amount=0 -> sr_select 11 then 00; res_data=8'b00110011 after 2 edges; no 01/10 ever driven.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid and res_data stable, cmd_ready=0, and a cmd_valid pulse during DONE is ignored. On res_ready=1, IDLE is reached on the next edge.
- Reset mid-SHIFT (dir=0, amount=7, rst_n low during the 3rd shift cycle) -> asynchronous return to IDLE: sr_select=00, res_valid=0, busy=0. A new command (8'hFF, dir=1, amount=4) then returns 8'h0F.
- Back-to-back: two queued commands with cmd_valid held high -> the second is accepted exactly one edge after the first result handshake; both results match the zero-fill shift reference model.
